// File: rtl/car_sensor_emulator.sv
// Emits one Gray-coded photo-sensor pass (a,b) per enter/exit request and
// tracks the occupancy the lot counter should be showing.
module car_sensor_emulator #(
    parameter int CLKS_PER_PHASE = 5_000_000,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_req,
    input  logic             exit_req,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_count
);

    localparam int TW = $clog2(CLKS_PER_PHASE);
    localparam logic [TW-1:0] TC = TW'(CLKS_PER_PHASE - 1);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        GUARD
    } state_t;

    state_t           r_state;
    logic             r_dir;
    logic [TW-1:0]    r_timer;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic             w_dir_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tc;

    assign w_tc = (r_timer == TC);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (enter_req) begin
                    w_state_nxt = PH1;
                    w_dir_nxt   = 1'b0;
                end else if (exit_req) begin
                    w_state_nxt = PH1;
                    w_dir_nxt   = 1'b1;
                end
            end
            PH1, PH2, PH3: begin
                if (w_tc) begin
                    w_timer_nxt = '0;
                    w_state_nxt = (r_state == PH1) ? PH2 :
                                  (r_state == PH2) ? PH3 : GUARD;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            GUARD: begin
                if (w_tc) begin
                    w_timer_nxt = '0;
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = r_dir ? r_cnt - 1'b1 : r_cnt + 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Sensor levels are decoded from the next state so a/b stay registered.
    always_comb begin
        w_a_nxt    = 1'b0;
        w_b_nxt    = 1'b0;
        w_busy_nxt = (w_state_nxt != IDLE);
        unique case (w_state_nxt)
            PH1: begin
                w_a_nxt = ~w_dir_nxt;
                w_b_nxt = w_dir_nxt;
            end
            PH2: begin
                w_a_nxt = 1'b1;
                w_b_nxt = 1'b1;
            end
            PH3: begin
                w_a_nxt = w_dir_nxt;
                w_b_nxt = ~w_dir_nxt;
            end
            default: begin
                w_a_nxt = 1'b0;
                w_b_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_timer <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign exp_count = r_cnt;

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: pass table plus scoreboard of per-cycle
// expected {a,b,busy,done,exp_count}, with a sensor decoder as loopback.
module tb_car_sensor_emulator;

    localparam int CPP = 4;
    localparam int CW  = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          enter_req = 1'b0;
    logic          exit_req  = 1'b0;
    logic          a;
    logic          b;
    logic          busy;
    logic          done;
    logic [CW-1:0] exp_count;

    car_sensor_emulator #(
        .CLKS_PER_PHASE(CPP),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enter_req(enter_req),
        .exit_req(exit_req),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .exp_count(exp_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {a,b,busy,done,exp_count}
    logic [7:0] sbq[$];

    typedef struct {
        logic       en;
        logic       ex;
        logic       hold;
        logic [1:0] mid;
        int         mid_at;
        logic       dir;
        logic [3:0] cnt_after;
        int         gap;
    } vec_t;

    vec_t tv[8];

    logic [CW-1:0] lb_cnt  = '0;
    logic [1:0]    prev_ab = 2'b00;
    logic [5:0]    hist    = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [1:0] pat(input logic dir, input int ph);
        logic [1:0] r;
        r = 2'b00;
        case (ph)
            0: r = dir ? 2'b01 : 2'b10;
            1: r = 2'b11;
            2: r = dir ? 2'b10 : 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // Checker and loopback decoder, sampled 1 unit after the active edge.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (reset) begin
            lb_cnt  = '0;
            prev_ab = 2'b00;
            hist    = '0;
        end else begin
            if ({a, b} != prev_ab) begin
                if ({a, b} == 2'b00) begin
                    if (hist == 6'b10_11_01) lb_cnt = lb_cnt + 1'b1;
                    else if (hist == 6'b01_11_10) lb_cnt = lb_cnt - 1'b1;
                    hist = '0;
                end else begin
                    hist = {hist[3:0], a, b};
                end
                prev_ab = {a, b};
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("outs", 32'({a, b, busy, done, exp_count}), 32'(e));
                if (e[4]) chk("loopback", 32'(lb_cnt), 32'(e[3:0]));
            end
        end
    end

    task automatic pass_seq(input vec_t v, input logic [3:0] cb,
                            input int last);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == 0) {enter_req, exit_req} = {v.en, v.ex};
            else if (i == v.mid_at) {enter_req, exit_req} = v.mid;
            else if (!v.hold) {enter_req, exit_req} = 2'b00;
            if (i < 4 * CPP)
                sbq.push_back({pat(v.dir, i / CPP), 2'b10, cb});
            else
                sbq.push_back({2'b00, 2'b01, v.cnt_after});
        end
    endtask

    task automatic idle(input int n, input logic [3:0] c);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {enter_req, exit_req} = 2'b00;
            sbq.push_back({2'b00, 2'b00, c});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cb;
        vec_t       v;

        tv[0] = '{1'b1, 1'b0, 1'b0, 2'b00, -1, 1'b0, 4'd1,  2};
        tv[1] = '{1'b0, 1'b1, 1'b0, 2'b00, -1, 1'b1, 4'd0,  2};
        tv[2] = '{1'b0, 1'b1, 1'b0, 2'b00, -1, 1'b1, 4'd15, 2};
        tv[3] = '{1'b1, 1'b0, 1'b0, 2'b00, -1, 1'b0, 4'd0,  2};
        tv[4] = '{1'b1, 1'b1, 1'b0, 2'b00, -1, 1'b0, 4'd1,  2};
        tv[5] = '{1'b1, 1'b0, 1'b0, 2'b01,  6, 1'b0, 4'd2,  3};
        tv[6] = '{1'b1, 1'b0, 1'b1, 2'b10, -1, 1'b0, 4'd3,  0};
        tv[7] = '{1'b1, 1'b0, 1'b1, 2'b10, -1, 1'b0, 4'd4,  3};

        #1 reset = 1'b1;
        #1;
        chk("rst_ab",   32'({a, b}),     32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        chk("rst_done", 32'(done),       32'd0);
        chk("rst_cnt",  32'(exp_count),  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2, 4'd0);

        cb = 4'd0;
        for (int k = 0; k < 8; k++) begin
            pass_seq(tv[k], cb, 4 * CPP);
            idle(tv[k].gap, tv[k].cnt_after);
            cb = tv[k].cnt_after;
        end

        // Abort an enter pass in the middle of PH2.
        v = '{1'b1, 1'b0, 1'b0, 2'b00, -1, 1'b0, 4'd5, 0};
        pass_seq(v, cb, 5);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_ab",   32'({a, b}),    32'd0);
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_done", 32'(done),      32'd0);
        chk("abort_cnt",  32'(exp_count), 32'd0);
        chk("abort_sbq",  32'(sbq.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #2 chk("abort_nodone", 32'({busy, done}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(1, 4'd0);
        v = '{1'b1, 1'b0, 1'b0, 2'b00, -1, 1'b0, 4'd1, 2};
        pass_seq(v, 4'd0, 4 * CPP);
        idle(2, 4'd1);

        @(posedge clk);
        #2 chk("sbq_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
